// File: rtl/ipa_ctx_pkg.sv
// Shared types and constants for the IPA context loader: FSM states, header field
// layout, payload packing factors and the words-per-phase helper.
package ipa_ctx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      INST,
      CONST,
      EXEC,
      WAIT_EXEC
   } ctx_state_t;

   localparam int HDR_LAST_BIT   = 0;
   localparam int HDR_IDX_LSB    = 1;
   localparam int HDR_IDX_W      = 8;
   localparam int HDR_NINST_LSB  = 9;
   localparam int HDR_NINST_W    = 7;
   localparam int HDR_NCONST_LSB = 16;
   localparam int HDR_NCONST_W   = 5;
   localparam int HDR_MASK_LSB   = 32;

   localparam int INST_PER_WORD  = 3;
   localparam int CONST_PER_WORD = 2;

   // Word counter is wide enough for ceil(127/3) instruction words.
   localparam int WCNT_W = 7;
   localparam int HCNT_W = 6;

   typedef logic [WCNT_W-1:0] wcnt_t;
   typedef logic [WCNT_W:0]   wsum_t;

   function automatic wcnt_t words_needed(input wcnt_t items, input int per_word);
      wsum_t sum;
      sum = {1'b0, items} + wsum_t'(per_word - 1);
      return wcnt_t'(sum / wsum_t'(per_word));
   endfunction

endpackage

// File: rtl/ipa_ctx_loader_if.sv
// Context memory read bus and tile configuration write bus of the IPA context loader.
interface ipa_ctx_loader_if #(
   parameter int GCM_ADDR_WIDTH = 9,
   parameter int OUT_ADDR_W     = 23
);

   logic                      ipa_gcm_req_o;
   logic [GCM_ADDR_WIDTH-1:0] Context_Addr;
   logic                      read_valid;
   logic [63:0]               In_Data;
   logic                      Write_En;
   logic [63:0]               Out_Data;
   logic [OUT_ADDR_W-1:0]     Out_Addr;

   modport master (
      output ipa_gcm_req_o,
      output Context_Addr,
      input  read_valid,
      input  In_Data,
      output Write_En,
      output Out_Data,
      output Out_Addr
   );

   modport slave (
      input  ipa_gcm_req_o,
      input  Context_Addr,
      output read_valid,
      output In_Data,
      input  Write_En,
      input  Out_Data,
      input  Out_Addr
   );

endinterface

// File: rtl/ipa_ctx_hdr_dec.sv
// Combinational tile header decoder: tile mask, payload word counts, last flag, error.
// IPA_CTX_BCAST_EN selects the broadcast mask in bits [63:32] instead of the tile index.
module ipa_ctx_hdr_dec
   import ipa_ctx_pkg::*;
#(
   parameter int NTILES = 16
) (
   input  logic [63:0]       hdr,
   output logic [NTILES-1:0] tile_mask,
   output wcnt_t             inst_words,
   output wcnt_t             const_words,
   output logic              last,
   output logic              tile_err
);

   wcnt_t n_inst;
   wcnt_t n_const;
   logic  hdr_unused;

   assign hdr_unused  = ^hdr;
   assign n_inst      = wcnt_t'(hdr[HDR_NINST_LSB +: HDR_NINST_W]);
   assign n_const     = wcnt_t'(hdr[HDR_NCONST_LSB +: HDR_NCONST_W]);
   assign last        = hdr[HDR_LAST_BIT];
   assign inst_words  = words_needed(n_inst, INST_PER_WORD);
   assign const_words = words_needed(n_const, CONST_PER_WORD);

`ifdef IPA_CTX_BCAST_EN
   assign tile_mask = hdr[HDR_MASK_LSB +: NTILES];
   assign tile_err  = (tile_mask == '0);
`else
   logic [HDR_IDX_W-1:0] idx;

   assign idx = hdr[HDR_IDX_LSB +: HDR_IDX_W];

   always_comb begin
      tile_mask = '0;
      for (int i = 0; i < NTILES; i++) begin
         tile_mask[i] = (idx == HDR_IDX_W'(i));
      end
   end

   assign tile_err = (idx >= HDR_IDX_W'(NTILES));
`endif

endmodule

// File: rtl/ipa_ctx_loader.sv
// Streams tile headers and instruction/constant payload from context memory into the PE
// array, then triggers execution. IPA_CTX_BCAST_EN enables broadcast tile masks.
module ipa_ctx_loader
   import ipa_ctx_pkg::*;
#(
   parameter int NB_ROWS        = 4,
   parameter int NB_COLS        = 4,
   parameter int GCM_ADDR_WIDTH = 9,
   parameter int SLOT_W         = 6,
   localparam int NTILES        = NB_ROWS * NB_COLS,
   localparam int OUT_ADDR_W    = NTILES + 1 + SLOT_W
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Context_Fetch_En,
   input  logic [GCM_ADDR_WIDTH-1:0] Context_Base,
   input  logic [4:0]                s_ipa_cfg_id,
   ipa_ctx_loader_if.master          bus,
   output logic                      Exec_En_Out,
   input  logic                      exec_comp,
   output logic                      busy_o,
   output logic                      err_o,
   output logic [4:0]                s_ipa_cfg_r_id
);

   ctx_state_t                state;
   logic [GCM_ADDR_WIDTH-1:0] addr_q;
   logic [4:0]                id_q;
   logic                      busy_q;
   logic                      err_q;
   logic                      exec_q;
   logic [NTILES-1:0]         mask_q;
   logic                      tile_err_q;
   logic                      last_q;
   wcnt_t                     inst_words_q;
   wcnt_t                     const_words_q;
   wcnt_t                     word_cnt;
   logic [HCNT_W-1:0]         hdr_cnt;

   logic                      req;
   logic                      accept;
   logic                      write_en;
   logic [NTILES-1:0]         dec_mask;
   wcnt_t                     dec_inst;
   wcnt_t                     dec_const;
   logic                      dec_last;
   logic                      dec_err;
   logic                      forced_end;
   logic                      tile_is_last;

   ipa_ctx_hdr_dec #(
      .NTILES(NTILES)
   ) u_hdr_dec (
      .hdr        (bus.In_Data),
      .tile_mask  (dec_mask),
      .inst_words (dec_inst),
      .const_words(dec_const),
      .last       (dec_last),
      .tile_err   (dec_err)
   );

   assign req      = (state == HDR) || (state == INST) || (state == CONST);
   assign accept   = req && bus.read_valid;
   assign write_en = ((state == INST) || (state == CONST)) && bus.read_valid && !tile_err_q;

   // A full array's worth of headers without a last flag ends the context as an error.
   assign forced_end   = (hdr_cnt == HCNT_W'(NTILES - 1)) && !dec_last;
   assign tile_is_last = dec_last || forced_end;

   assign bus.ipa_gcm_req_o = req;
   assign bus.Context_Addr  = addr_q;
   assign bus.Write_En      = write_en;
   assign bus.Out_Data      = write_en ? bus.In_Data : '0;
   assign bus.Out_Addr      = write_en ? {SLOT_W'(word_cnt), (state == CONST), mask_q} : '0;

   assign Exec_En_Out    = exec_q;
   assign busy_o         = busy_q;
   assign err_o          = err_q;
   assign s_ipa_cfg_r_id = busy_q ? id_q : '0;

   // Loader sequencer; exec_q is set on the transition into EXEC so it is high for
   // exactly the single cycle spent there.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state         <= IDLE;
         addr_q        <= '0;
         id_q          <= '0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         exec_q        <= 1'b0;
         mask_q        <= '0;
         tile_err_q    <= 1'b0;
         last_q        <= 1'b0;
         inst_words_q  <= '0;
         const_words_q <= '0;
         word_cnt      <= '0;
         hdr_cnt       <= '0;
      end else begin
         exec_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Context_Fetch_En) begin
                  addr_q  <= Context_Base;
                  id_q    <= s_ipa_cfg_id;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  hdr_cnt <= '0;
                  state   <= HDR;
               end
            end
            HDR: begin
               if (accept) begin
                  addr_q        <= addr_q + 1'b1;
                  hdr_cnt       <= hdr_cnt + 1'b1;
                  mask_q        <= dec_mask;
                  tile_err_q    <= dec_err;
                  last_q        <= tile_is_last;
                  inst_words_q  <= dec_inst;
                  const_words_q <= dec_const;
                  word_cnt      <= '0;
                  if (dec_err || forced_end) begin
                     err_q <= 1'b1;
                  end
                  if (dec_inst != '0) begin
                     state <= INST;
                  end else if (dec_const != '0) begin
                     state <= CONST;
                  end else if (tile_is_last) begin
                     state  <= EXEC;
                     exec_q <= 1'b1;
                  end else begin
                     state <= HDR;
                  end
               end
            end
            INST: begin
               if (accept) begin
                  addr_q <= addr_q + 1'b1;
                  if (word_cnt == inst_words_q - 1'b1) begin
                     word_cnt <= '0;
                     if (const_words_q != '0) begin
                        state <= CONST;
                     end else if (last_q) begin
                        state  <= EXEC;
                        exec_q <= 1'b1;
                     end else begin
                        state <= HDR;
                     end
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            CONST: begin
               if (accept) begin
                  addr_q <= addr_q + 1'b1;
                  if (word_cnt == const_words_q - 1'b1) begin
                     word_cnt <= '0;
                     if (last_q) begin
                        state  <= EXEC;
                        exec_q <= 1'b1;
                     end else begin
                        state <= HDR;
                     end
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            EXEC: begin
               state <= WAIT_EXEC;
            end
            WAIT_EXEC: begin
               if (exec_comp) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ipa_ctx_loader.md
IPA_CTX_LOADER -- requirements
Module: ipa_ctx_loader

Interface
REQ-001 SHALL have parameter NB_ROWS, default 4, meaning PE array rows.
REQ-002 SHALL have parameter NB_COLS, default 4, meaning PE array columns; NTILES = NB_ROWS*NB_COLS, legal range 1..32.
REQ-003 SHALL have parameter GCM_ADDR_WIDTH, default 9, meaning context memory word-address width.
REQ-004 SHALL have parameter SLOT_W, default 6, meaning per-tile instruction/constant slot address width.
REQ-005 SHALL have ports: Clk in 1, clock; Reset in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: Context_Fetch_En in 1, start pulse; Context_Base in GCM_ADDR_WIDTH, first header address; s_ipa_cfg_id in 5, requester id.
REQ-007 SHALL have ports: ipa_gcm_req_o out 1, read request; Context_Addr out GCM_ADDR_WIDTH, read address; read_valid in 1, In_Data valid; In_Data in 64, GCM word.
REQ-008 SHALL have ports: Write_En out 1; Out_Data out 64; Out_Addr out NTILES+1+SLOT_W, {slot, const_sel, tile mask}.
REQ-009 SHALL have ports: Exec_En_Out out 1, execute pulse; exec_comp in 1, execution done; busy_o out 1; err_o out 1, sticky error; s_ipa_cfg_r_id out 5, latched id.

Function
REQ-010 SHALL implement states IDLE, HDR, INST, CONST, EXEC, WAIT_EXEC.
REQ-011 SHALL, in IDLE on Context_Fetch_En, load Context_Addr=Context_Base, latch s_ipa_cfg_id, clear err_o, set busy_o, go to HDR; Context_Fetch_En outside IDLE is ignored.
REQ-012 SHALL assert ipa_gcm_req_o in HDR, INST, CONST only; a word is accepted when ipa_gcm_req_o & read_valid, and Context_Addr increments by 1 (wrapping modulo 2^GCM_ADDR_WIDTH) on each acceptance only.
REQ-013 SHALL decode an accepted header: bit0 last-tile, [8:1] tile index, [15:9] N_inst, [20:16] N_const.
REQ-014 SHALL fetch ceil(N_inst/3) instruction words then ceil(N_const/2) constant words per tile; zero counts skip the phase; both zero returns to HDR (or EXEC if last).
REQ-015 SHALL drive Write_En=1, Out_Data=In_Data in the same cycle as each accepted INST/CONST word (zero latency); Write_En=0 otherwise.
REQ-016 SHALL drive Out_Addr mask = one-hot(tile index), const_sel=0 in INST / 1 in CONST, slot = word counter starting at 0 per phase; Out_Addr=0 when Write_En=0.
REQ-017 SHALL treat tile index >= NTILES as error: set err_o, consume that tile's payload words with Write_En=0.
REQ-018 SHALL go to EXEC after the last-tile header's payload, or after NTILES headers without last flag (then also set err_o).
REQ-019 SHALL pulse Exec_En_Out for exactly one cycle in EXEC, then wait in WAIT_EXEC until exec_comp=1, then clear busy_o and return to IDLE.
REQ-020 SHALL drive s_ipa_cfg_r_id = latched id while busy_o=1, 0 otherwise.
REQ-021 SHALL hold all counters and outputs stable across read_valid=0 stall cycles.

Reset
REQ-022 SHALL, on Reset=0 at any time including mid-transfer, go to IDLE and force all outputs and counters to 0 asynchronously.

Configuration
REQ-023 SHALL, with IPA_CTX_BCAST_EN defined, take the tile mask from header bits [63:32] (low NTILES bits, multiple bits = broadcast), error if mask is zero, and ignore [8:1].
REQ-024 SHALL, without IPA_CTX_BCAST_EN, use one-hot index decoding only and ignore [63:32].

Structure
REQ-025 SHALL place the state enum, header field positions, and packing constants (3 inst/word, 2 const/word) in package ipa_ctx_pkg.
REQ-026 SHALL use one sub-module ipa_ctx_hdr_dec (combinational header -> mask, word counts, last, error).

Verification
REQ-027 SHALL test: base=0x10, one header last=1 idx=5 N_inst=7 N_const=3 -> 3 writes mask 0x0020 const_sel=0 slots 0..2, 2 writes const_sel=1 slots 0..1, Exec_En_Out one cycle, Context_Addr ends 0x16.
REQ-028 SHALL test: read_valid toggled every other cycle in the above -> identical write sequence, no duplicated or dropped words.
REQ-029 SHALL test: header idx=20 with NTILES=16 N_inst=3 -> err_o=1, one word consumed, Write_En stays 0.
REQ-030 SHALL test: 16 headers none last -> EXEC entered after 16th tile, err_o=1.
REQ-031 SHALL test: Reset low during CONST phase -> all outputs 0 immediately, next Context_Fetch_En restarts cleanly.
REQ-032 SHALL test with IPA_CTX_BCAST_EN: mask 0x0000_00F0 N_inst=3 -> one write with Out_Addr mask 0x00F0.
